// File: rtl/clk_tick_gen.sv
// Multi-channel tick / square-wave generator.
// Per-channel programmable divisor, shadowed until the next wrap.
module clk_tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 4,
  parameter int SEL_W       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_chan,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              tick_sel,
  output logic              sq_sel
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] nxt_div;
    logic             sq_q, sq_d;
    logic             wr_hit;
    logic             wrap;

    assign wr_hit  = wr_en && (wr_chan == SEL_W'(i));
    assign wrap    = (cnt_q == act_q);
    // Bypass makes a write landing on the wrap edge take effect at once.
    assign nxt_div = wr_hit ? wr_data : shd_q;
    assign tick[i] = en[i] && wrap;
    assign sq[i]   = sq_q;

    always_comb begin
      cnt_d = cnt_q;
      sq_d  = sq_q;
      act_d = act_q;
      shd_d = wr_hit ? wr_data : shd_q;
      if (!en[i]) begin
        cnt_d = '0;
        sq_d  = 1'b0;
        act_d = nxt_div;
      end else if (wrap) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
        act_d = nxt_div;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        shd_q <= DIV_RST;
        act_q <= DIV_RST;
        sq_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        shd_q <= shd_d;
        act_q <= act_d;
        sq_q  <= sq_d;
      end
    end
  end

  // Zero padding makes out-of-range selects read as 0.
  logic [NSEL-1:0] tick_ext;
  logic [NSEL-1:0] sq_ext;

  assign tick_ext = NSEL'(tick);
  assign sq_ext   = NSEL'(sq);
  assign tick_sel = tick_ext[sel];
  assign sq_sel   = sq_ext[sel];

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed self-checking bench for clk_tick_gen.
// Two channels, 2-bit selectors, default divisor 4.
module tb_clk_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [31:0] wr_data;
  logic [1:0]  sel;
  logic [1:0]  tick;
  logic [1:0]  sq;
  logic        tick_sel;
  logic        sq_sel;

  int n_chk  = 0;
  int n_fail = 0;

  clk_tick_gen #(
    .NUM_CH(2),
    .WIDTH(32),
    .DEFAULT_DIV(4),
    .SEL_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .wr_en(wr_en),
    .wr_chan(wr_chan),
    .wr_data(wr_data),
    .sel(sel),
    .tick(tick),
    .sq(sq),
    .tick_sel(tick_sel),
    .sq_sel(sq_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_data = d;
  endtask

  logic [1:0] e_t, e_s;

  initial begin
    rst_n   = 1'b0;
    en      = 2'b00;
    wr_en   = 1'b0;
    wr_chan = 2'd0;
    wr_data = 32'd0;
    sel     = 2'd0;
    #12;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_tsel", 32'(tick_sel), 32'd0);
    chk("rst_ssel", 32'(sq_sel), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("dis_tick", 32'(tick), 32'd0);

    // default period 5 on both channels
    en = 2'b11;
    #1;
    for (int k = 0; k <= 14; k++) begin
      e_t = (k % 5 == 4) ? 2'b11 : 2'b00;
      e_s = ((k / 5) % 2 == 1) ? 2'b11 : 2'b00;
      chk($sformatf("p5_tick_k%0d", k), 32'(tick), 32'(e_t));
      chk($sformatf("p5_sq_k%0d", k), 32'(sq), 32'(e_s));
      if (k != 14) step();
    end

    // ch1 divisor 9 written mid-period
    en = 2'b00;
    step();
    en = 2'b11;
    #1;
    for (int k = 0; k <= 24; k++) begin
      e_t[0] = (k % 5 == 4);
      e_t[1] = (k == 4 || k == 14 || k == 24);
      e_s[0] = ((k / 5) % 2 == 1);
      e_s[1] = (k >= 5 && k <= 14);
      chk($sformatf("d9_tick_k%0d", k), 32'(tick), 32'(e_t));
      chk($sformatf("d9_sq_k%0d", k), 32'(sq), 32'(e_s));
      if (k == 2) wr(2'd1, 32'd9);
      if (k == 3) wr_en = 1'b0;
      if (k != 24) step();
    end

    // ch0 divisor 0 written on the wrap cycle
    en = 2'b00;
    step();
    en = 2'b11;
    #1;
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("d0_tick_k%0d", k), 32'(tick[0]), 32'(k >= 4));
      chk($sformatf("d0_sq_k%0d", k), 32'(sq[0]),
          32'(k >= 5 && ((k - 5) % 2 == 0)));
      if (k == 4) wr(2'd0, 32'd0);
      if (k == 5) wr_en = 1'b0;
      if (k != 10) step();
    end

    // restore ch0 divisor 4, then drop enable mid-count
    wr(2'd0, 32'd4);
    step();
    wr_en = 1'b0;
    en = 2'b10;
    step();
    en = 2'b11;
    #1;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("en_tick_k%0d", k), 32'(tick[0]), 32'(k == 4));
      if (k != 8) step();
    end
    chk("en_sq_before", 32'(sq[0]), 32'd1);
    en = 2'b10;
    #1;
    chk("en_drop_comb", 32'(tick[0]), 32'd0);
    step();
    chk("en_drop_tick", 32'(tick[0]), 32'd0);
    chk("en_drop_sq", 32'(sq[0]), 32'd0);
    en = 2'b11;
    #1;
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("reen_tick_k%0d", k), 32'(tick[0]), 32'(k == 4));
      if (k != 4) step();
    end

    // selector routing and out-of-range indices
    en = 2'b00;
    step();
    en  = 2'b11;
    sel = 2'd0;
    #1;
    for (int k = 0; k <= 14; k++) begin
      if (k == 5) begin
        sel = 2'd1;
        #1;
      end
      chk($sformatf("sel_tsel_k%0d", k), 32'(tick_sel),
          32'(k < 5 ? (k == 4) : (k == 9)));
      if (k == 12) chk("sel1_ssel", 32'(sq_sel), 32'd1);
      if (k == 14) begin
        sel = 2'd0;
        #1;
        chk("sel0_same_cyc", 32'(tick_sel), 32'd1);
        sel = 2'd3;
        #1;
        chk("sel3_same_cyc", 32'(tick_sel), 32'd0);
      end
      step();
    end
    for (int k = 15; k <= 34; k++) begin
      e_t[0] = (k % 5 == 4);
      e_t[1] = (k % 10 == 9);
      chk($sformatf("sel3_tick_k%0d", k), 32'(tick), 32'(e_t));
      chk($sformatf("sel3_tsel_k%0d", k), 32'(tick_sel), 32'd0);
      chk($sformatf("sel3_ssel_k%0d", k), 32'(sq_sel), 32'd0);
      if (k == 15) wr(2'd3, 32'd0);
      if (k == 30) wr(2'd1, 32'd2);
      if (k == 16 || k == 31) wr_en = 1'b0;
      if (k != 34) step();
    end

    // async reset between edges, pending ch1 shadow discarded
    #2;
    chk("pre_rst_tick", 32'(tick), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_sq", 32'(sq), 32'd0);
    sel = 2'd0;
    #1;
    chk("arst_tsel", 32'(tick_sel), 32'd0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k <= 12; k++) begin
      e_t = (k % 5 == 4) ? 2'b11 : 2'b00;
      e_s = ((k / 5) % 2 == 1) ? 2'b11 : 2'b00;
      chk($sformatf("post_tick_k%0d", k), 32'(tick), 32'(e_t));
      chk($sformatf("post_sq_k%0d", k), 32'(sq), 32'(e_s));
      if (k != 12) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Parametrised multi-channel clock-enable (tick) generator; next generation of the fixed two-channel divide-by-5 divider.
- Each channel has a runtime-programmable divisor, a per-channel enable, a one-cycle tick pulse and a 50%-duty square-wave output.
- A channel selector drives a shared tick/square output.
- Sits between the board clock and slower logic (timers, display scan, blinkers); all downstream logic stays on clk and uses ticks as enables.

Parameters:
- NUM_CH, 2, number of channels (1..16)
- WIDTH, 32, counter/divisor width in bits
- DEFAULT_DIV, 4, divisor loaded into every channel at reset (tick period = DEFAULT_DIV+1)
- SEL_W, 1, width of channel index ports; must satisfy 2^SEL_W >= NUM_CH

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset; deassertion assumed synchronous to clk externally
- en  input  NUM_CH  per-channel enable, bit i = channel i
- wr_en  input  1  divisor write strobe, one write per cycle
- wr_chan  input  SEL_W  channel index for write
- wr_data  input  WIDTH  new divisor value
- sel  input  SEL_W  channel routed to tick_sel/sq_sel
- tick  output  NUM_CH  one-cycle pulse per channel
- sq  output  NUM_CH  square wave per channel
- tick_sel  output  1  tick[sel]
- sq_sel  output  1  sq[sel]

Behaviour:
- Per-channel state: cnt[WIDTH], div_shadow[WIDTH], div_act[WIDTH], sq register.
- Reset (rst_n low, async): cnt=0, div_shadow=div_act=DEFAULT_DIV, sq=0; therefore tick=0, tick_sel=0, sq_sel=0.
- tick[i] = en[i] && (cnt == div_act), decoded from registers only, with no input-to-output path except en.
- Enabled channel, each rising edge:
  - If cnt == div_act (wrap): cnt <= 0; sq <= ~sq; div_act <= next divisor.
  - Otherwise: cnt <= cnt+1.
- Period is div_act+1 cycles. div=0 gives tick every cycle and sq toggling every cycle.
- After enable rises with cnt=0, the first tick occurs in the (div_act+1)th enabled cycle.
- Next divisor = wr_data if a write to this channel occurs in the same cycle, else div_shadow. The write bypass guarantees a determinate result on a simultaneous write and wrap.
- Write: when wr_en and wr_chan == i, div_shadow[i] <= wr_data on the edge.
  - Enabled channel: the new value takes effect only at the next wrap; the current period always completes with the old divisor (glitch-free sq).
- Disabled channel (en[i]=0), each edge: cnt <= 0; sq <= 0; div_act <= next divisor. tick[i]=0.
- Re-enable restarts a full period from cnt=0.
- Out-of-range indices:
  - wr_chan >= NUM_CH: write ignored.
  - sel >= NUM_CH: tick_sel=0, sq_sel=0.
- tick_sel/sq_sel: combinational mux of tick/sq by sel; changing sel switches within the same cycle, with no retiming.
- Counter never exceeds div_act. Arithmetic is unsigned WIDTH-bit; div = 2^WIDTH-1 wraps correctly with no overflow beyond div_act.
- Reset asserted mid-period: immediate return to reset values, and any pending shadow divisor is lost.

Test Plan:
- Reset, NUM_CH=2, en=2'b11, no writes -> tick[0] and tick[1] high on cycles 4, 9, 14 after enable; sq toggles on each; sq period 10 cycles.
- Write div=9 to ch1 at cnt=2 -> current period ends with tick at cnt=4; following ticks are 10 cycles apart; ch0 is unaffected.
- Write div=0 to ch0 in the exact cycle cnt==div_act -> after that wrap, tick[0] is high every cycle and sq[0] toggles every cycle.
- en[0] dropped mid-count at cnt=3 -> tick[0]=0 and sq[0]=0 from the next edge; on re-enable the first tick comes 5 cycles later.
- sel=0 then 1 then 3 (SEL_W=2, NUM_CH=2) -> tick_sel follows tick[0], then tick[1], then is constant 0; a write with wr_chan=3 changes no divisor.
- rst_n pulsed low asynchronously between edges while ticking -> outputs go to 0 immediately, divisors return to 4, and ticking resumes at period 5.
